// File: rtl/reg_write_queue_pkg.sv
// Shared definitions for the register write-back queue: the hardwired register
// indices (same list the file register ties off) and the FIFO operation encoding.
package reg_write_queue_pkg;

    localparam int unsigned R_ZERO   = 0;
    localparam int unsigned R_9      = 9;
    localparam int unsigned R_10     = 10;
    localparam int unsigned R_11     = 11;
    localparam int unsigned R_12     = 12;
    localparam int unsigned DROP_MAX = 255;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Writes to these indices are discarded; reads of them never hazard.
    function automatic logic is_const_reg(input int unsigned idx);
        return (idx == R_ZERO) || (idx == R_9) || (idx == R_10) ||
               (idx == R_11) || (idx == R_12);
    endfunction

endpackage

// File: rtl/reg_write_fifo.sv
// Pending-write storage: circular buffer with head/tail/count, plus an
// oldest-first view of every slot and its valid bit for the hazard scan.
module reg_write_fifo
    import reg_write_queue_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned ADDR_WIDTH = 4,
    parameter  int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned CNT_W      = PTR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_addr,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [CNT_W-1:0]      o_count,
    output logic [ADDR_WIDTH-1:0] o_head_addr,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [ADDR_WIDTH-1:0] o_age_addr  [DEPTH],
    output logic [DATA_WIDTH-1:0] o_age_data  [DEPTH],
    output logic                  o_age_valid [DEPTH]
);

    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    fifo_op_e              w_op;

    assign w_op = fifo_op_e'({i_push, i_pop});

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    r_tail  <= r_tail + 1'b1;
                    r_count <= r_count + 1'b1;
                end
                OP_POP: begin
                    r_head  <= r_head + 1'b1;
                    r_count <= r_count - 1'b1;
                end
                OP_BOTH: begin
                    r_tail <= r_tail + 1'b1;
                    r_head <= r_head + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush && i_push) begin
            r_mem_addr[r_tail] <= i_push_addr;
            r_mem_data[r_tail] <= i_push_data;
        end
    end

    // Slot k of the view is the k-th oldest entry; pointer sum wraps naturally.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            o_age_addr[k]  = r_mem_addr[r_head + PTR_W'(k)];
            o_age_data[k]  = r_mem_data[r_head + PTR_W'(k)];
            o_age_valid[k] = (CNT_W'(k) < r_count);
        end
    end

    assign o_count     = r_count;
    assign o_head_addr = r_mem_addr[r_head];
    assign o_head_data = r_mem_data[r_head];

endmodule

// File: rtl/reg_write_queue.sv
// Write-side front end of the file register: filters hardwired-register writes,
// queues the rest, drains one per cycle and forwards the newest pending value.
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wb_hold,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  hazard_a,
    output logic                  hazard_b,
    output logic [DATA_WIDTH-1:0] fwd_a,
    output logic [DATA_WIDTH-1:0] fwd_b,
    output logic [ADDR_WIDTH-1:0] addr_d,
    output logic [DATA_WIDTH-1:0] data_bus,
    output logic                  rw,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]      w_count;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_age_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] w_age_data  [DEPTH];
    logic                  w_age_valid [DEPTH];
    logic                  w_req_const;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_rw;
    logic [7:0]            r_drop_cnt;

    assign w_req_const = is_const_reg(32'(req_addr));
    assign w_ready     = reset & ~flush & (w_count < CNT_W'(DEPTH));
    assign w_accept    = req_valid & w_ready;
    assign w_push      = w_accept & ~w_req_const;
    assign w_rw        = reset & ~flush & ~wb_hold & (w_count != '0);

    assign req_ready = w_ready;
    assign rw        = w_rw;
    assign addr_d    = w_rw ? w_head_addr : '0;
    assign data_bus  = w_rw ? w_head_data : '0;
    assign drop_cnt  = r_drop_cnt;

    reg_write_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_reset_n   (reset),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_addr (req_addr),
        .i_push_data (req_data),
        .i_pop       (w_rw),
        .o_count     (w_count),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_age_addr  (w_age_addr),
        .o_age_data  (w_age_data),
        .o_age_valid (w_age_valid)
    );

    // Oldest-to-youngest scan: a later match overwrites, so the youngest wins.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        fwd_a    = '0;
        fwd_b    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_age_valid[k] && (w_age_addr[k] == rd_addr_a)) begin
                hazard_a = 1'b1;
                fwd_a    = w_age_data[k];
            end
            if (w_age_valid[k] && (w_age_addr[k] == rd_addr_b)) begin
                hazard_b = 1'b1;
                fwd_b    = w_age_data[k];
            end
        end
        if (!reset || is_const_reg(32'(rd_addr_a))) begin
            hazard_a = 1'b0;
            fwd_a    = '0;
        end
        if (!reset || is_const_reg(32'(rd_addr_b))) begin
            hazard_b = 1'b0;
            fwd_b    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_req_const && (r_drop_cnt != 8'(DROP_MAX))) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: directed scenarios, drop-counter
// saturation, then randomized traffic against a queue-based reference model.
module tb_reg_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset, flush, wb_hold, req_valid, req_ready;
    logic [3:0]  req_addr, rd_addr_a, rd_addr_b, addr_d;
    logic [15:0] req_data, fwd_a, fwd_b, data_bus;
    logic        hazard_a, hazard_b, rw;
    logic [7:0]  drop_cnt;

    wr_t         pend[$];
    wr_t         sb[$];
    int unsigned m_drops = 0;
    bit          m_known = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    reg_write_queue #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wb_hold   (wb_hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .addr_d    (addr_d),
        .data_bus  (data_bus),
        .rw        (rw),
        .drop_cnt  (drop_cnt)
    );

    function automatic bit is_const(input logic [3:0] a);
        return (a == 4'd0) || (a >= 4'd9 && a <= 4'd12);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_hazard(input logic [3:0] ra, input bit rst,
                                       output bit h, output logic [15:0] f);
        h = 1'b0;
        f = '0;
        if (rst && !is_const(ra))
            foreach (pend[i])
                if (pend[i].a == ra) begin
                    h = 1'b1;
                    f = pend[i].d;
                end
    endfunction

    task automatic cycle(input bit rst, input bit fl, input bit hold, input bit v,
                         input logic [3:0] a, input logic [15:0] d,
                         input logic [3:0] ra, input logic [3:0] rb);
        bit          e_ready, e_rw, e_ha, e_hb;
        logic [15:0] e_fa, e_fb;
        wr_t         w;
        @(negedge clk);
        reset = rst; flush = fl; wb_hold = hold; req_valid = v;
        req_addr = a; req_data = d; rd_addr_a = ra; rd_addr_b = rb;
        #2;
        e_ready = rst && !fl && (pend.size() < DEPTH);
        e_rw    = rst && !fl && !hold && (pend.size() != 0);
        ref_hazard(ra, rst, e_ha, e_fa);
        ref_hazard(rb, rst, e_hb, e_fb);
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("rw", 32'(rw), 32'(e_rw));
        if (!e_rw) begin
            check("addr_d_idle", 32'(addr_d), 32'(0));
            check("data_bus_idle", 32'(data_bus), 32'(0));
        end
        check("hazard_a", 32'(hazard_a), 32'(e_ha));
        check("fwd_a", 32'(fwd_a), 32'(e_fa));
        check("hazard_b", 32'(hazard_b), 32'(e_hb));
        check("fwd_b", 32'(fwd_b), 32'(e_fb));
        if (m_known)
            check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        @(posedge clk);
        if (!rst) begin
            pend.delete();
            sb.delete();
            m_drops = 0;
            m_known = 1'b1;
        end else if (fl) begin
            pend.delete();
            sb.delete();
        end else begin
            if (e_rw)
                void'(pend.pop_front());
            if (v && e_ready) begin
                if (is_const(a)) begin
                    if (m_drops < 255)
                        m_drops++;
                end else begin
                    w.a = a;
                    w.d = d;
                    pend.push_back(w);
                    sb.push_back(w);
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] ra, input logic [3:0] rb);
        for (int i = 0; i < n; i++)
            cycle(1, 0, 0, 0, 4'd0, 16'd0, ra, rb);
    endtask

    // Monitor: every write presented to the file register must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rw === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_spurious actual rw=1 addr=%0h data=%0h required no write @%0t",
                             addr_d, data_bus, $time);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(addr_d), 32'(e.a));
                    check("wr_data", 32'(data_bus), 32'(e.d));
                end
            end
        end
    end

    initial begin
        reset = 0; flush = 0; wb_hold = 0; req_valid = 0;
        req_addr = '0; req_data = '0; rd_addr_a = '0; rd_addr_b = '0;

        // Reset and idle
        cycle(0, 0, 0, 0, 4'd0, 16'd0, 4'd0, 4'd0);
        cycle(0, 0, 0, 0, 4'd0, 16'd0, 4'd0, 4'd0);
        idle(2, 4'd3, 4'd5);

        // Single write, minimum latency
        cycle(1, 0, 0, 1, 4'd3, 16'hBEEF, 4'd3, 4'd0);
        idle(2, 4'd3, 4'd3);

        // Fill under hold, duplicate destinations, youngest forward
        cycle(1, 0, 1, 1, 4'd5, 16'd1, 4'd5, 4'd7);
        cycle(1, 0, 1, 1, 4'd5, 16'd2, 4'd5, 4'd7);
        cycle(1, 0, 1, 1, 4'd7, 16'd3, 4'd5, 4'd7);
        cycle(1, 0, 1, 1, 4'd1, 16'd4, 4'd5, 4'd1);
        cycle(1, 0, 1, 1, 4'd6, 16'd9, 4'd5, 4'd6);
        for (int i = 0; i < 5; i++)
            cycle(1, 0, 0, 0, 4'd0, 16'd0, 4'd5, 4'd1);

        // Constant-register writes are dropped
        cycle(1, 0, 0, 1, 4'd0,  16'h1234, 4'd0, 4'd9);
        cycle(1, 0, 0, 1, 4'd9,  16'h1234, 4'd0, 4'd9);
        cycle(1, 0, 0, 1, 4'd12, 16'h1234, 4'd12, 4'd9);
        idle(2, 4'd9, 4'd0);

        // Flush with a request present
        cycle(1, 0, 1, 1, 4'd2, 16'hAAAA, 4'd2, 4'd4);
        cycle(1, 0, 1, 1, 4'd4, 16'hBBBB, 4'd2, 4'd4);
        cycle(1, 0, 1, 1, 4'd2, 16'hCCCC, 4'd2, 4'd4);
        cycle(1, 1, 0, 1, 4'd8, 16'hDDDD, 4'd2, 4'd4);
        idle(2, 4'd2, 4'd4);

        // Streaming push and drain every cycle
        for (int i = 1; i <= 8; i++)
            cycle(1, 0, 0, 1, 4'(i), 16'(16'h1000 + i), 4'(i), 4'(i - 1));
        idle(2, 4'd8, 4'd7);

        // Drop counter saturation
        for (int i = 0; i < 260; i++)
            cycle(1, 0, 0, 1, 4'd10, 16'(i), 4'd10, 4'd0);
        idle(2, 4'd0, 4'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(6, 4'd0, 4'd0);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drained actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
